// File: rtl/bcd_sched_pkg.sv
// ---------------------------------------------------------------------------
// Package: bcd_sched_pkg
// Shared constants and types for the binary->BCD conversion scheduler.
//   BIN_W     operand width (values 0..127)
//   DIGIT_W   width of one BCD digit
//   TEN       subtrahend used by the iterative engine
//   state_t   scheduler FSM encoding
//   ptr_width helper: index width for a given channel count (minimum 1 bit)
// ---------------------------------------------------------------------------
package bcd_sched_pkg;

  localparam int BIN_W   = 7;
  localparam int DIGIT_W = 4;
  localparam logic [BIN_W-1:0] TEN = 7'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A single-channel build still needs a 1-bit pointer/index.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_rr_arbiter.sv
// ---------------------------------------------------------------------------
// Module: bcd_rr_arbiter
// Combinational round-robin arbiter. Grants the first requester at or after
// ptr, wrapping around to channel 0.
//   req      in   NUM_CH   request vector
//   ptr      in   PTR_W    highest-priority channel this round
//   gnt      out  NUM_CH   one-hot grant (all zero when no request)
//   gnt_idx  out  PTR_W    index of the granted channel
//   any      out  1        at least one request present
// ---------------------------------------------------------------------------
module bcd_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              any
);

  // Two passes avoid modulo index arithmetic: the first finds the lowest
  // requester at or above ptr; only if none exists does the second pass pick
  // the lowest requester overall, which is then necessarily below ptr.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!any && req[c] && (c >= int'(ptr))) begin
        any     = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = PTR_W'(c);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!any && req[c]) begin
        any     = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = PTR_W'(c);
      end
    end
  end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// ---------------------------------------------------------------------------
// Module: bcd_conv_scheduler
// One iterative binary->BCD engine (repeated subtract-10) shared among NUM_CH
// requesters by round-robin arbitration, with a held set of BCD digit
// registers per channel for the 7-segment display drivers.
//
// Configuration macro: BCD_SCHED_HUNDREDS_EN
//   defined   : values >= 100 produce a hundreds digit (hund_flat port)
//   undefined : values >= 100 saturate the display at 99 and raise ovf
//
// Ports
//   clk        in   1           system clock, rising edge
//   rst        in   1           asynchronous active-low reset
//   req        in   NUM_CH      level request per channel, held until ack
//   bin_flat   in   NUM_CH*7    channel c operand at [c*7+:7], sampled at grant
//   ack        out  NUM_CH      1-cycle pulse when a channel's digits update
//   ones_flat  out  NUM_CH*4    channel c ones digit at [c*4+:4]
//   tens_flat  out  NUM_CH*4    channel c tens digit at [c*4+:4]
//   hund_flat  out  NUM_CH      hundreds digit (0/1) per channel (macro defined)
//   ovf        out  NUM_CH      >99 flag, held until that channel's next
//                               conversion (macro undefined)
//   busy       out  1           high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module bcd_conv_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH*BIN_W-1:0]   bin_flat,
  output logic [NUM_CH-1:0]         ack,
  output logic [NUM_CH*DIGIT_W-1:0] ones_flat,
  output logic [NUM_CH*DIGIT_W-1:0] tens_flat,
`ifdef BCD_SCHED_HUNDREDS_EN
  output logic [NUM_CH-1:0]         hund_flat,
`else
  output logic [NUM_CH-1:0]         ovf,
`endif
  output logic                      busy
);

  localparam int PTR_W = ptr_width(NUM_CH);

  // Engine and scheduler state
  state_t               state_reg;
  logic [BIN_W-1:0]     opnd_reg;
  logic [DIGIT_W-1:0]   tens_cnt_reg;
  logic [PTR_W-1:0]     ch_reg;
  logic [NUM_CH-1:0]    gnt_reg;
  logic [PTR_W-1:0]     ptr_reg;
  logic [NUM_CH-1:0]    ack_reg;
  logic                 busy_reg;

  // Per-channel held results; flag_reg is the hundreds digit or the ovf bit
  logic [DIGIT_W-1:0]   ones_reg [NUM_CH];
  logic [DIGIT_W-1:0]   tens_reg [NUM_CH];
  logic [NUM_CH-1:0]    flag_reg;

  // Arbiter interface
  logic [NUM_CH-1:0]    gnt;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 any;
  logic [PTR_W-1:0]     ptr_next;

  // Operand view per channel
  logic [BIN_W-1:0]     bin_arr [NUM_CH];

  // Final digits computed from the engine state once opnd < 10
  logic [DIGIT_W-1:0]   res_ones;
  logic [DIGIT_W-1:0]   res_tens;
  logic                 res_flag;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign bin_arr[gi]                          = bin_flat[gi*BIN_W +: BIN_W];
      assign ones_flat[gi*DIGIT_W +: DIGIT_W]     = ones_reg[gi];
      assign tens_flat[gi*DIGIT_W +: DIGIT_W]     = tens_reg[gi];
    end
  endgenerate

  bcd_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_reg),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Priority moves to the channel just after the winner.
  assign ptr_next = (gnt_idx == PTR_W'(NUM_CH-1)) ? '0 : gnt_idx + PTR_W'(1);

  // In SUB with opnd < 10 the remainder is the ones digit and tens_cnt holds
  // floor(bin/10), which reaches at most 12 for a 7-bit operand.
  always_comb begin
    res_ones = opnd_reg[DIGIT_W-1:0];
    res_tens = tens_cnt_reg;
    res_flag = 1'b0;
    if (tens_cnt_reg >= 4'd10) begin
`ifdef BCD_SCHED_HUNDREDS_EN
      res_flag = 1'b1;
      res_tens = tens_cnt_reg - 4'd10;
`else
      res_flag = 1'b1;
      res_ones = 4'd9;
      res_tens = 4'd9;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      opnd_reg     <= '0;
      tens_cnt_reg <= '0;
      ch_reg       <= '0;
      gnt_reg      <= '0;
      ptr_reg      <= '0;
      ack_reg      <= '0;
      busy_reg     <= 1'b0;
      flag_reg     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        ones_reg[c] <= '0;
        tens_reg[c] <= '0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any) begin
            opnd_reg     <= bin_arr[gnt_idx];
            tens_cnt_reg <= '0;
            ch_reg       <= gnt_idx;
            gnt_reg      <= gnt;
            ptr_reg      <= ptr_next;
            busy_reg     <= 1'b1;
            state_reg    <= ST_SUB;
          end
        end
        ST_SUB: begin
          if (opnd_reg >= TEN) begin
            opnd_reg     <= opnd_reg - TEN;
            tens_cnt_reg <= tens_cnt_reg + 4'd1;
          end else begin
            ones_reg[ch_reg] <= res_ones;
            tens_reg[ch_reg] <= res_tens;
            flag_reg[ch_reg] <= res_flag;
            // gnt_reg is one-hot, so only the served channel is acked.
            ack_reg          <= gnt_reg;
            state_reg        <= ST_DONE;
          end
        end
        ST_DONE: begin
          // req is not looked at here; the requester gets this cycle to drop it.
          ack_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          ack_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack  = ack_reg;
  assign busy = busy_reg;
`ifdef BCD_SCHED_HUNDREDS_EN
  assign hund_flat = flag_reg;
`else
  assign ovf       = flag_reg;
`endif

endmodule
